// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU's program encoder and instruction decoder:
// opcodes, error-bit positions, encoder FSM states and encoding helpers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_LI    = 4'h7;
  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_LT    = 4'h9;
  localparam logic [3:0] OP_NOT   = 4'hA;

  localparam int ERR_ILL = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_RNG = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } enc_state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_NOT;
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LT, OP_NOT: return {op, rd, rs};
      OP_LOAD, OP_STORE, OP_LI, OP_JUMP:            return {op, imm[3:0]};
      default:                                      return 8'h00;
    endcase
  endfunction

  // LOAD/STORE offsets are signed 4-bit; LI/JUMP immediates are unsigned 4-bit.
  function automatic logic imm_in_range(input logic [3:0] op, input logic [7:0] imm);
    case (op)
      OP_LOAD, OP_STORE: return (imm[7:3] == 5'b00000) || (imm[7:3] == 5'b11111);
      OP_LI, OP_JUMP:    return imm[7:4] == 4'h0;
      default:           return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO for encoded bytes; head entry is presented from storage
// registers so a push in cycle N is visible at the head in cycle N+1.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == CNT_W'(DEPTH));
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_en    = push && (!full || pop);
  assign pop_en     = pop && head_valid;

  // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; contents are only observed while count marks them valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prog_encoder.sv
// Program writer: encodes symbolic instruction requests into {opcode, operand}
// bytes and streams them into instruction memory. Optional immediate range
// checking is enabled with the PROG_ENC_RANGE_CHECK_EN macro.
module prog_encoder
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [1:0]        req_rd,
  input  logic [1:0]        req_rs,
  input  logic [7:0]        req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err
);

  enc_state_t        state;
  enc_state_t        state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   wr_count;
  logic [2:0]        err_q;
  logic              done_q;

  logic              start_acc;
  logic              push;
  logic [8:0]        push_entry;
  logic              head_valid;
  logic [8:0]        head;
  logic              fifo_full;
  logic              mem_full;
  logic              pop;
  logic              wr_fire;
  logic              last_pop;
  logic              rng_viol;

  assign start_acc  = (state == ST_IDLE) && start;
  assign push       = req_valid && req_ready;
  assign push_entry = {encode(req_op, req_rd, req_rs, req_imm), req_last};

  // Once the whole memory has been written, entries drain without a write.
  assign mem_full = wr_count[ADDR_W];
  assign wr_fire  = imem_we && imem_ready;
  assign pop      = head_valid && (mem_full || imem_ready);
  assign last_pop = pop && head[0];

`ifdef PROG_ENC_RANGE_CHECK_EN
  assign rng_viol = push && !imm_in_range(req_op, req_imm);
`else
  assign rng_viol = 1'b0;
`endif

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head),
    .full       (fifo_full)
  );

  // NOTE: next-state is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)            state_nxt = ST_LOAD;
      ST_LOAD:  if (push && req_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_pop)         state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      wr_count <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_DRAIN) && last_pop;
      if (start_acc) begin
        addr     <= base_addr;
        wr_count <= '0;
        err_q    <= '0;
      end else begin
        if (wr_fire) begin
          addr     <= addr + 1'b1;
          wr_count <= wr_count + 1'b1;
        end
        if (push && !is_legal(req_op)) err_q[ERR_ILL] <= 1'b1;
        if (pop && mem_full)           err_q[ERR_OVF] <= 1'b1;
        if (rng_viol)                  err_q[ERR_RNG] <= 1'b1;
      end
    end
  end

  assign req_ready  = (state == ST_LOAD) && !fifo_full;
  assign busy       = (state != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign imem_we    = head_valid && !mem_full;
  assign imem_addr  = addr;
  assign imem_wdata = head_valid ? head[8:1] : 8'h00;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder: load sessions with hand-computed bytes,
// error flags, memory overflow, write-port stall and mid-session reset.
module tb_prog_encoder;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [1:0]        req_rd;
  logic [1:0]        req_rs;
  logic [7:0]        req_imm;
  logic              req_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              imem_ready;
  logic              busy;
  logic              done;
  logic [2:0]        err;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [7:0]        exp_data_q[$];

  prog_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_rs     (req_rs),
    .req_imm    (req_imm),
    .req_last   (req_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ready (imem_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so the negedge view matches what the next edge sees.
  always @(negedge clk) begin
    if (!rst && imem_we && imem_ready) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    step();
    start     = 1'b1;
    base_addr = b;
    step();
    start     = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt  = 0;
  endtask

  // Caller must be aligned 1ns after a posedge.
  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [7:0] imm, input logic last);
    bit ok;
    ok        = 1'b0;
    req_op    = op;
    req_rd    = rd;
    req_rs    = rs;
    req_imm   = imm;
    req_last  = last;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      step();
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt, 1);
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic check_log();
    check("write_count", wr_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("write_addr[%0d]", i), wr_addr_q[i], exp_addr_q[i]);
      check($sformatf("write_data[%0d]", i), wr_data_q[i], exp_data_q[i]);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    req_valid  = 1'b0;
    req_op     = 4'h0;
    req_rd     = 2'd0;
    req_rs     = 2'd0;
    req_imm    = 8'h00;
    req_last   = 1'b0;
    imem_ready = 1'b1;

    // Reset values, during and after reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_err", err, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 0);
    check("idle_busy", busy, 0);

    // ADD r1,r2 then LI 9 at base 0.
    do_start(4'd0);
    @(negedge clk);
    check("s1_busy_after_start", busy, 1);
    check("s1_ready_after_start", req_ready, 1);
    step();
    send(4'h1, 2'd1, 2'd2, 8'h00, 1'b0);
    @(negedge clk);
    check("s1_latency_we", imem_we, 1);
    check("s1_latency_data", imem_wdata, 8'h16);
    check("s1_latency_addr", imem_addr, 0);
    step();
    send(4'h7, 2'd0, 2'd0, 8'd9, 1'b1);
    wait_done();
    expect_write(4'd0, 8'h16);
    expect_write(4'd1, 8'h79);
    check_log();
    check("s1_err", err, 3'b000);

    // LOAD -3 / STORE 7 at the top of memory.
    do_start(4'd14);
    send(4'h5, 2'd0, 2'd0, 8'hFD, 1'b0);
    send(4'h6, 2'd0, 2'd0, 8'h07, 1'b1);
    wait_done();
    expect_write(4'd14, 8'h5D);
    expect_write(4'd15, 8'h67);
    check_log();
    check("s2_err", err, 3'b000);

    // Illegal opcode C, then NOP with non-zero fields.
    do_start(4'd3);
    send(4'hC, 2'd3, 2'd3, 8'hFF, 1'b0);
    send(4'h0, 2'd3, 2'd2, 8'hAB, 1'b1);
    wait_done();
    expect_write(4'd3, 8'h00);
    expect_write(4'd4, 8'h00);
    check_log();
    check("s3_err_ill", err, 3'b001);

    // LI 20: truncated to 4, range flag only with checking enabled.
    do_start(4'd7);
    send(4'h7, 2'd0, 2'd0, 8'd20, 1'b1);
    wait_done();
    expect_write(4'd7, 8'h74);
    check_log();
`ifdef PROG_ENC_RANGE_CHECK_EN
    check("s4_err_rng", err, 3'b100);
`else
    check("s4_err_rng", err, 3'b000);
`endif

    // 17 ADDs into a 16-byte memory: the 17th drains without a write.
    do_start(4'd0);
    for (int i = 0; i < 17; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      send(4'h1, iv[3:2], iv[1:0], 8'h00, i == 16);
    end
    wait_done();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      expect_write(iv, {4'h1, iv});
    end
    check_log();
    check("s5_err_ovf", err, 3'b010);

    // Write-port stall: FIFO fills, write signals hold, nothing lost or duplicated.
    do_start(4'd5);
    imem_ready = 1'b0;
    req_op = 4'h1; req_rd = 2'd0; req_rs = 2'd1; req_imm = 8'h00; req_last = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    check("s6_ready_first", req_ready, 1);
    step();
    req_op = 4'h2; req_rd = 2'd2; req_rs = 2'd3;
    @(negedge clk);
    check("s6_we_first", imem_we, 1);
    check("s6_addr_first", imem_addr, 5);
    check("s6_data_first", imem_wdata, 8'h11);
    check("s6_ready_second", req_ready, 1);
    step();
    req_op = 4'h3; req_rd = 2'd1; req_rs = 2'd1; req_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("s6_full_ready[%0d]", k), req_ready, 0);
      check($sformatf("s6_hold_we[%0d]", k), imem_we, 1);
      check($sformatf("s6_hold_addr[%0d]", k), imem_addr, 5);
      check($sformatf("s6_hold_data[%0d]", k), imem_wdata, 8'h11);
      step();
    end
    imem_ready = 1'b1;
    send(4'h3, 2'd1, 2'd1, 8'h00, 1'b1);
    wait_done();
    expect_write(4'd5, 8'h11);
    expect_write(4'd6, 8'h2B);
    expect_write(4'd7, 8'h35);
    check_log();
    check("s6_err", err, 3'b000);

    // Reset mid-session with a pending write and a sticky error.
    do_start(4'd9);
    imem_ready = 1'b0;
    send(4'hF, 2'd0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    check("s7_pre_err", err, 3'b001);
    check("s7_pre_we", imem_we, 1);
    check("s7_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("s7_rst_req_ready", req_ready, 0);
    check("s7_rst_imem_we", imem_we, 0);
    check("s7_rst_busy", busy, 0);
    check("s7_rst_done", done, 0);
    check("s7_rst_imem_addr", imem_addr, 0);
    check("s7_rst_imem_wdata", imem_wdata, 0);
    check("s7_rst_err", err, 0);
    step();
    step();
    rst        = 1'b0;
    imem_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("s7_no_writes", wr_addr_q.size(), 0);
    check("s7_idle_busy", busy, 0);
    check("s7_idle_we", imem_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
